req_rsp_responder: RTL and testbench
====================================

Name: req_rsp_responder

Overview:
- Synthesizable responder at the far end of the team's valid/ready request/response interface; the initiator is the testbench driver.
- Accepts single read/write requests and services them against an internal register file.
- Returns one response per request after a fixed, parameterized latency; honours response backpressure.
- Serves as the reference DUT that exercises driver, monitor and scoreboard end-to-end.

Parameters:
- ADDR_WIDTH, 4, request address width in bits.
- DATA_WIDTH, 32, register and data bus width in bits.
- NUM_REGS, 12, number of implemented registers; must be ≤ 2**ADDR_WIDTH.
- RSP_LATENCY, 2, number of wait cycles between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  initiator has a request.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  register index.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  error flag; constant 0 unless RSP_ERR_EN is defined.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All registers = 0.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
- FSM states:
  - IDLE: req_ready = 1. On req_valid & req_ready, accept the request, then go to WAIT if RSP_LATENCY > 0, else to RESP.
  - WAIT: req_ready = 0. Counter loads RSP_LATENCY-1 at accept and decrements each cycle; go to RESP when the counter is 0.
  - RESP: rsp_valid = 1. On rsp_valid & rsp_ready, go to IDLE.
- Acceptance edge (same edge the request is accepted):
  - Write commits to the register file on that edge.
  - Read data and the error flag are captured into response registers on that edge.
  - A later write cannot alter an in-flight read response; only one request is outstanding by construction.
- Latency: rsp_valid rises RSP_LATENCY+1 cycles after the accept edge.
  - RSP_LATENCY = 0 gives rsp_valid on the cycle after the accept edge.
- Response hold: rsp_rdata and rsp_err stay stable while rsp_valid = 1 and rsp_ready = 0, for an unbounded number of cycles.
- Throughput:
  - req_ready is 0 from the cycle after accept until the cycle after the response handshake.
  - No same-cycle response/request overlap.
  - Maximum throughput is one request per RSP_LATENCY+2 cycles.
- req_valid asserted outside IDLE is ignored; the initiator must hold the request per protocol.
- Out-of-range address (req_addr ≥ NUM_REGS): write is dropped; read returns 0.
- rst_n asserted mid-transaction: immediate return to IDLE; any pending response is discarded; registers clear to 0.

Optional Feature:
- Macro: RSP_ERR_EN.
- Defined: an out-of-range address (read or write) sets rsp_err = 1 on its response; the access is still dropped and reads return 0. In-range accesses give rsp_err = 0.
- Undefined: rsp_err is tied 0 and out-of-range accesses are silently dropped.

Decomposition:
- Shared package req_rsp_pkg contains:
  - rsp_state_t enum {IDLE, WAIT, RESP}.
  - Packed struct rsp_t {rdata, err}.
  - Localparam LAT_CNT_W = 4.
- One sub-module, req_rsp_regfile:
  - NUM_REGS x DATA_WIDTH flops with async reset.
  - Write enable, address-range check, combinational read port, in_range output.
- The top level holds the FSM, latency counter and response registers.

Test Plan:
- Write 0xDEADBEEF to addr 3, then read addr 3 with RSP_LATENCY = 2 -> read rsp_valid rises exactly 3 cycles after the accept edge; rsp_rdata = 0xDEADBEEF; rsp_err = 0.
- Read addr 5 and hold rsp_ready = 0 for 10 cycles -> rsp_valid stays 1, rsp_rdata is stable, req_ready stays 0 and busy stays 1; on rsp_ready = 1 the handshake occurs, and req_ready = 1 on the next cycle.
- RSP_LATENCY = 0 with back-to-back write/read to addr 0 (value 0x1) -> each rsp_valid appears 1 cycle after accept; read returns 0x1; requests are accepted every 2 cycles.
- Write 0x55 to addr 14 (NUM_REGS = 12), then read addr 14 -> read returns 0. With RSP_ERR_EN defined both responses have rsp_err = 1; without it rsp_err = 0.
- Assert rst_n low during WAIT after writing 0xA5 to addr 2 -> rsp_valid never asserts; state is IDLE with req_ready = 1 immediately; a read of addr 2 after reset returns 0.
- Assert req_valid continuously with a changing req_addr while in WAIT/RESP -> no extra acceptance occurs; exactly one response per accepted request (scoreboard count matches).

Source files
------------

// File: rtl/req_rsp_pkg.sv
// Shared types for the request/response responder.
// Responder FSM states, response record and latency-counter width.
package req_rsp_pkg;

    localparam int unsigned LAT_CNT_W  = 4;
    localparam int unsigned RSP_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } rsp_state_t;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_t;

endpackage

// File: rtl/req_rsp_regfile.sv
// Register file behind the responder: NUM_REGS words with async clear,
// one write port, combinational read port and an address range flag.
module req_rsp_regfile #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  in_range
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    assign in_range = (32'(addr) < NUM_REGS);

    // Out-of-range addresses match no entry, so writes drop and reads give 0.
    always_comb begin
        regs_d = regs_q;
        rdata  = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(addr) == i) begin
                rdata = regs_q[i];
                if (we) begin
                    regs_d[i] = wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/req_rsp_responder.sv
// Valid/ready responder: one outstanding request, fixed-latency response.
// Define RSP_ERR_EN to flag out-of-range accesses on rsp_err.
module req_rsp_responder
    import req_rsp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_REGS    = 12,
    parameter int unsigned RSP_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    rsp_state_t             state_q, state_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    rsp_t                   rsp_q, rsp_d;
    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   in_range;

    req_rsp_regfile #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (wr_en),
        .addr     (req_addr),
        .wdata    (req_wdata),
        .rdata    (rd_data),
        .in_range (in_range)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rsp_d   = rsp_q;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    // Response is captured here so later writes cannot disturb it.
                    wr_en       = req_write & in_range;
                    rsp_d.rdata = req_write ? '0 : RSP_DATA_W'(rd_data);
`ifdef RSP_ERR_EN
                    rsp_d.err   = ~in_range;
`else
                    rsp_d.err   = 1'b0;
`endif
                    if (RSP_LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = LAT_CNT_W'(RSP_LATENCY - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rsp_q   <= rsp_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_rdata = DATA_WIDTH'(rsp_q.rdata);
    assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_req_rsp_responder.sv
// Directed bench for req_rsp_responder: latency 2 instance plus a latency 0 instance.
// Honours RSP_ERR_EN for the expected error flag.
module tb_req_rsp_responder;

`ifdef RSP_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_req_valid = 1'b0, a_req_ready, a_req_write = 1'b0;
    logic [3:0]  a_req_addr = '0;
    logic [31:0] a_req_wdata = '0, a_rsp_rdata;
    logic        a_rsp_valid, a_rsp_ready = 1'b0, a_rsp_err, a_busy;

    logic        b_req_valid = 1'b0, b_req_ready, b_req_write = 1'b0;
    logic [3:0]  b_req_addr = '0;
    logic [31:0] b_req_wdata = '0, b_rsp_rdata;
    logic        b_rsp_valid, b_rsp_ready = 1'b1, b_rsp_err, b_busy;

    req_rsp_responder #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(12), .RSP_LATENCY(2)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .busy(a_busy)
    );

    req_rsp_responder #(
        .ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(12), .RSP_LATENCY(0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int a_acc_cnt = 0;
    int a_rsp_cnt = 0;
    int b_acc_cyc[$];

    always @(posedge clk) begin
        cyc++;
        if (a_req_valid && a_req_ready) a_acc_cnt++;
        if (a_rsp_valid && a_rsp_ready) a_rsp_cnt++;
        if (b_req_valid && b_req_ready) b_acc_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request on DUT A; returns the number of cycles until rsp_valid.
    task automatic send_req(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                            output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        a_req_valid = 1'b1;
        a_req_write = wr;
        a_req_addr  = addr;
        a_req_wdata = wd;
        a_rsp_ready = 1'b0;
        while (!a_req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            a_req_valid = 1'b0;
        end while (!a_rsp_valid && lat < 40);
    endtask

    task automatic finish_rsp(input string tag);
        a_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_rsp_ready = 1'b0;
        check({tag, "_ready_after"}, 32'(a_req_ready), 32'd1);
    endtask

    initial begin
        int lat;
        int acc0, rsp0;
        logic seen;

        #1;
        check("rst_req_ready", 32'(a_req_ready), 32'd1);
        check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("rst_rdata", a_rsp_rdata, 32'h0);
        check("rst_err", 32'(a_rsp_err), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Latency 0 instance: write then read addr 0 back to back
        @(negedge clk);
        b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 4'd0; b_req_wdata = 32'h1;
        @(posedge clk);
        @(negedge clk);
        check("l0_wr_valid", 32'(b_rsp_valid), 32'd1);
        check("l0_wr_rdata", b_rsp_rdata, 32'h0);
        b_req_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("l0_idle_ready", 32'(b_req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        b_req_valid = 1'b0;
        check("l0_rd_valid", 32'(b_rsp_valid), 32'd1);
        check("l0_rd_rdata", b_rsp_rdata, 32'h1);
        @(posedge clk);
        @(negedge clk);
        check("l0_accepts", 32'(b_acc_cyc.size()), 32'd2);
        if (b_acc_cyc.size() >= 2)
            check("l0_accept_spacing", 32'(b_acc_cyc[1] - b_acc_cyc[0]), 32'd2);

        // Write then read addr 3 with latency 2
        send_req(1'b1, 4'd3, 32'hDEADBEEF, lat);
        check("wr3_lat", 32'(lat), 32'd3);
        check("wr3_rdata", a_rsp_rdata, 32'h0);
        finish_rsp("wr3");
        send_req(1'b0, 4'd3, 32'h0, lat);
        check("rd3_lat", 32'(lat), 32'd3);
        check("rd3_rdata", a_rsp_rdata, 32'hDEADBEEF);
        check("rd3_err", 32'(a_rsp_err), 32'd0);
        finish_rsp("rd3");

        // Backpressure hold on read of addr 5
        send_req(1'b1, 4'd5, 32'h12345678, lat);
        finish_rsp("wr5");
        send_req(1'b0, 4'd5, 32'h0, lat);
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", 32'(a_rsp_valid), 32'd1);
            check("hold_rdata", a_rsp_rdata, 32'h12345678);
            check("hold_req_ready", 32'(a_req_ready), 32'd0);
            check("hold_busy", 32'(a_busy), 32'd1);
            @(negedge clk);
        end
        finish_rsp("hold");
        check("hold_valid_after", 32'(a_rsp_valid), 32'd0);

        // Out-of-range address 14
        send_req(1'b1, 4'd14, 32'h55, lat);
        check("oor_wr_err", 32'(a_rsp_err), 32'(EXP_ERR));
        finish_rsp("oor_wr");
        send_req(1'b0, 4'd14, 32'h0, lat);
        check("oor_rd_rdata", a_rsp_rdata, 32'h0);
        check("oor_rd_err", 32'(a_rsp_err), 32'(EXP_ERR));
        finish_rsp("oor_rd");
        send_req(1'b0, 4'd5, 32'h0, lat);
        check("inrange_err", 32'(a_rsp_err), 32'd0);
        finish_rsp("inrange");

        // req_valid held with changing address outside IDLE
        send_req(1'b1, 4'd7, 32'h77, lat);
        finish_rsp("wr7");
        send_req(1'b1, 4'd8, 32'h88, lat);
        finish_rsp("wr8");
        acc0 = a_acc_cnt;
        rsp0 = a_rsp_cnt;
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 4'd7;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_req_addr = 4'(8 + i);
        end
        a_req_valid = 1'b0;
        check("ign_valid", 32'(a_rsp_valid), 32'd1);
        check("ign_rdata", a_rsp_rdata, 32'h77);
        finish_rsp("ign");
        repeat (2) @(negedge clk);
        check("ign_accepts", 32'(a_acc_cnt - acc0), 32'd1);
        check("ign_responses", 32'(a_rsp_cnt - rsp0), 32'd1);

        // Reset during WAIT after write of 0xA5 to addr 2
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 4'd2; a_req_wdata = 32'hA5;
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        check("mid_busy", 32'(a_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(a_req_ready), 32'd1);
        check("mid_rst_busy", 32'(a_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_rsp_valid) seen = 1'b1;
        end
        check("mid_no_rsp", 32'(seen), 32'd0);
        send_req(1'b0, 4'd2, 32'h0, lat);
        check("mid_rd2_lat", 32'(lat), 32'd3);
        check("mid_rd2_rdata", a_rsp_rdata, 32'h0);
        finish_rsp("mid_rd2");
        send_req(1'b0, 4'd3, 32'h0, lat);
        check("mid_rd3_rdata", a_rsp_rdata, 32'h0);
        finish_rsp("mid_rd3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
